// File: rtl/axis_sched_pkg.sv
// Shared definitions for the 8-FIFO AXI-Stream round-robin scheduler.
package axis_sched_pkg;

   // bus_sel code space: SEL_BASE+idx selects FIFO idx, 0 selects nothing.
   localparam logic [7:0] SEL_BASE        = 8'd128;
   localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_XFER = 1'b1
   } state_t;

   // Map a channel index onto its bus_sel code.
   function automatic logic [7:0] sel_code(input logic [2:0] idx);
      return SEL_BASE + {5'd0, idx};
   endfunction

endpackage

// File: rtl/axis_fifo_rr_sched_rr_arb8.sv
// Combinational 8-way rotating-priority arbiter.
// The search starts one past last_idx, so the previous winner is considered last.
module rr_arb8 (
   input  logic [7:0] req,
   input  logic [2:0] last_idx,
   output logic [2:0] win_idx,
   output logic       win_vld
);

   logic [2:0] cand;

   // Walk last_idx+1 .. last_idx+8 (mod 8) and keep the first requester found.
   always_comb begin
      win_vld = 1'b0;
      win_idx = last_idx;
      cand    = last_idx;
      for (int k = 1; k <= 8; k++) begin
         cand = last_idx + 3'(k);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

endmodule

// File: rtl/axis_fifo_rr_sched.sv
// Packet-granular round-robin scheduler for the 8-FIFO AXI-Stream read path.
// Grants hold from the first beat to the tlast beat; grants chain without a bubble.
// Optional per-channel packet counters: define AXIS_SCHED_PKT_CNT_EN.
// The bus_sel base code lives in axis_sched_pkg (SEL_BASE).
module axis_fifo_rr_sched
   import axis_sched_pkg::*;
#(
   parameter int unsigned N_CH    = 8,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sched_en,
   input  logic [N_CH-1:0]   ch_req,
   input  logic              axis_tvalid,
   input  logic              axis_tready,
   input  logic              axis_tlast,
   input  logic              stall_clr,
   output logic [7:0]        bus_sel,
   output logic [N_CH-1:0]   grant_oh,
   output logic              busy,
   output logic              stall_err
`ifdef AXIS_SCHED_PKT_CNT_EN
   ,
   output logic [N_CH*CNT_W-1:0] pkt_cnt
`endif
);

   localparam int unsigned    TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  T_MAX = TW'(TIMEOUT);
   localparam logic [TW-1:0]  T_PRE = TW'(TIMEOUT - 1);

   // Reject configurations the bus_sel code space or the timer cannot express.
   if (N_CH != 8 || TIMEOUT < 2 || CNT_W < 1) begin : g_bad_cfg
      $error("axis_fifo_rr_sched: unsupported N_CH/TIMEOUT/CNT_W");
   end

   state_t          state;
   logic [2:0]      last_idx;
   logic [TW-1:0]   timer;
   logic [2:0]      win_idx;
   logic            win_vld;
   logic            beat;
   logic            end_beat;
   logic            new_grant;
   logic            stall_set;

   rr_arb8 u_arb (
      .req      (ch_req),
      .last_idx (last_idx),
      .win_idx  (win_idx),
      .win_vld  (win_vld)
   );

   // Beat qualification and grant / stall events.
   always_comb begin
      beat      = (state == S_XFER) & axis_tvalid & axis_tready;
      end_beat  = beat & axis_tlast;
      new_grant = sched_en & win_vld & ((state == S_IDLE) | end_beat);
      // Set only on the transition into TIMEOUT so a clear holds during a long stall.
      stall_set = (state == S_XFER) & ~beat & (timer == T_PRE);
   end

   // Scheduler FSM with registered grant outputs.
   always_ff @(posedge clk or posedge rst) begin : fsm
      if (rst) begin
         state    <= S_IDLE;
         bus_sel  <= NON_FIFO_CHOOSE;
         grant_oh <= '0;
         busy     <= 1'b0;
         last_idx <= 3'd7;
      end else begin
         case (state)
            S_IDLE: begin
               if (sched_en && win_vld) begin
                  state    <= S_XFER;
                  bus_sel  <= sel_code(win_idx);
                  grant_oh <= N_CH'(1) << win_idx;
                  busy     <= 1'b1;
                  last_idx <= win_idx;
               end
            end
            S_XFER: begin
               // The grant is only ever re-evaluated on the packet's tlast beat.
               if (end_beat) begin
                  if (sched_en && win_vld) begin
                     bus_sel  <= sel_code(win_idx);
                     grant_oh <= N_CH'(1) << win_idx;
                     last_idx <= win_idx;
                  end else begin
                     state    <= S_IDLE;
                     bus_sel  <= NON_FIFO_CHOOSE;
                     grant_oh <= '0;
                     busy     <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // No-progress timer and sticky stall flag; a set beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin : stall_mon
      if (rst) begin
         timer     <= '0;
         stall_err <= 1'b0;
      end else begin
         if (stall_set) begin
            stall_err <= 1'b1;
         end else if (stall_clr) begin
            stall_err <= 1'b0;
         end
         if (stall_clr || beat || new_grant || (state != S_XFER)) begin
            timer <= '0;
         end else if (timer != T_MAX) begin
            timer <= timer + TW'(1);
         end
      end
   end

`ifdef AXIS_SCHED_PKT_CNT_EN
   // Count completed packets per channel; counters wrap modulo 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin : pkt_count
      if (rst) begin
         pkt_cnt <= '0;
      end else if (end_beat) begin
         for (int i = 0; i < N_CH; i++) begin
            if (grant_oh[i]) begin
               pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end
`else
   // Packet counters are not built in this configuration.
`endif

endmodule
